// File: rtl/axi_w_channel_slave_no_burst.sv
// Single-beat AXI write slave: captures AW and W in either order, issues one SRAM write, then a B response.
// Optional macro AXI_SLAVE_PROTOCOL_CHECK_EN turns malformed requests into SLVERR with the SRAM write suppressed.
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif

module axi_w_channel_slave_no_burst #(
   parameter int DATA_WIDTH = `AXI_DATA_WIDTH,
   parameter int ADDR_WIDTH = `AXI_ADDR_WIDTH,
   parameter int ID_WIDTH   = `AXI_ID_WIDTH,
   parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
   input  logic                  ACLK,
   input  logic                  ARESETn,
   input  logic [ADDR_WIDTH-1:0] AWADDR,
   input  logic [3:0]            AWLEN,
   input  logic [2:0]            AWSIZE,
   input  logic [1:0]            AWBURST,
   input  logic [ID_WIDTH-1:0]   AWID,
   input  logic                  AWVALID,
   output logic                  AWREADY,
   input  logic [DATA_WIDTH-1:0] WDATA,
   input  logic [STRB_WIDTH-1:0] WSTRB,
   input  logic                  WLAST,
   input  logic [ID_WIDTH-1:0]   WID,
   input  logic                  WVALID,
   output logic                  WREADY,
   output logic [1:0]            BRESP,
   output logic [ID_WIDTH-1:0]   BID,
   output logic                  BVALID,
   input  logic                  BREADY,
   output logic                  ram_wen,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_wdata,
   output logic [STRB_WIDTH-1:0] ram_wmask,
   output logic                  busy
);

   typedef enum logic [2:0] {
      IDLE  = 3'b001,
      WRITE = 3'b010,
      RESP  = 3'b100
   } state_t;

   state_t state, next_state;

   logic                  aw_got, w_got;
   logic [ADDR_WIDTH-1:0] aw_addr_q;
   logic [3:0]            aw_len_q;
   logic [2:0]            aw_size_q;
   logic [ID_WIDTH-1:0]   aw_id_q;
   logic [DATA_WIDTH-1:0] w_data_q;
   logic [STRB_WIDTH-1:0] w_strb_q;
   logic                  w_last_q;
   logic [ID_WIDTH-1:0]   w_id_q;
   logic [1:0]            bresp_q;

   logic                  aw_hs, w_hs, go, prot_err;
   logic [ADDR_WIDTH-1:0] addr_e;
   logic [3:0]            len_e;
   logic [2:0]            size_e;
   logic [ID_WIDTH-1:0]   id_e, wid_e;
   logic [DATA_WIDTH-1:0] data_e;
   logic [STRB_WIDTH-1:0] strb_e;
   logic                  last_e;
   logic                  unused_sig;

   // NOTE: readies are gated by ARESETn so they drop the instant reset asserts, not at the next edge.
   assign AWREADY = ARESETn && (state == IDLE) && !aw_got;
   assign WREADY  = ARESETn && (state == IDLE) && !w_got;
   assign aw_hs   = AWVALID && AWREADY;
   assign w_hs    = WVALID && WREADY;
   assign go      = (state == IDLE) && (aw_got || aw_hs) && (w_got || w_hs);

   // The completing handshake may be this cycle, so take each field from the bus if not yet captured.
   assign addr_e = aw_got ? aw_addr_q : AWADDR;
   assign len_e  = aw_got ? aw_len_q  : AWLEN;
   assign size_e = aw_got ? aw_size_q : AWSIZE;
   assign id_e   = aw_got ? aw_id_q   : AWID;
   assign data_e = w_got  ? w_data_q  : WDATA;
   assign strb_e = w_got  ? w_strb_q  : WSTRB;
   assign last_e = w_got  ? w_last_q  : WLAST;
   assign wid_e  = w_got  ? w_id_q    : WID;

`ifdef AXI_SLAVE_PROTOCOL_CHECK_EN
   assign prot_err   = (len_e != 4'd0) || (size_e > 3'b010) || !last_e || (wid_e != id_e);
   assign unused_sig = ^AWBURST;
`else
   assign prot_err   = 1'b0;
   assign unused_sig = ^{AWBURST, len_e, size_e, last_e, wid_e};
`endif

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) state <= IDLE;
      else          state <= next_state;
   end

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:    if (go) next_state = WRITE;
         WRITE:   next_state = RESP;
         RESP:    if (BREADY) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only so every register samples pre-edge values.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         aw_got    <= 1'b0;
         w_got     <= 1'b0;
         aw_addr_q <= '0;
         aw_len_q  <= '0;
         aw_size_q <= '0;
         aw_id_q   <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         w_last_q  <= 1'b0;
         w_id_q    <= '0;
         bresp_q   <= 2'b00;
         ram_wen   <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
         ram_wmask <= '0;
      end else begin
         if (aw_hs) begin
            aw_got    <= 1'b1;
            aw_addr_q <= AWADDR;
            aw_len_q  <= AWLEN;
            aw_size_q <= AWSIZE;
            aw_id_q   <= AWID;
         end
         if (w_hs) begin
            w_got    <= 1'b1;
            w_data_q <= WDATA;
            w_strb_q <= WSTRB;
            w_last_q <= WLAST;
            w_id_q   <= WID;
         end
         if ((state == RESP) && BREADY) begin
            aw_got <= 1'b0;
            w_got  <= 1'b0;
         end
         ram_wen <= go && !prot_err;
         if (go && !prot_err) begin
            ram_addr  <= addr_e;
            ram_wdata <= data_e;
            ram_wmask <= strb_e;
         end
         if (go) bresp_q <= prot_err ? 2'b10 : 2'b00;
      end
   end

   assign BVALID = (state == RESP);
   assign BID    = aw_id_q;
   assign BRESP  = bresp_q;
   assign busy   = (state != IDLE) || aw_got || w_got;

endmodule

// File: doc/axi_w_channel_slave_no_burst.md
AXI_W_CHANNEL_SLAVE_NO_BURST -- requirements
Module: axi_w_channel_slave_no_burst

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default `AXI_DATA_WIDTH, giving the data bus width.
REQ-002 SHALL have parameter ADDR_WIDTH, default `AXI_ADDR_WIDTH, giving the address width.
REQ-003 SHALL have parameter ID_WIDTH, default `AXI_ID_WIDTH, giving the transaction ID width.
REQ-004 SHALL have parameter STRB_WIDTH, default DATA_WIDTH/8, giving the byte-strobe width.
REQ-005 SHALL have ports as follows:
- ACLK  in  1  sole clock; all state on rising edge.
- ARESETn  in  1  reset; asynchronous and active-low.
- AWADDR  in  ADDR_WIDTH  write address.
- AWLEN  in  4  beats minus one.
- AWSIZE  in  3  beat size.
- AWBURST  in  2  burst type.
- AWID  in  ID_WIDTH  address ID.
- AWVALID / AWREADY  in / out  1  AW handshake.
- WDATA  in  DATA_WIDTH  write data.
- WSTRB  in  STRB_WIDTH  byte strobes.
- WLAST  in  1  last beat.
- WID  in  ID_WIDTH  data ID.
- WVALID / WREADY  in / out  1  W handshake.
- BRESP  out  2  response; 2'b00 OKAY, 2'b10 SLVERR.
- BID  out  ID_WIDTH  response ID.
- BVALID / BREADY  out / in  1  B handshake.
- ram_wen  out  1  single-cycle SRAM write strobe.
- ram_addr  out  ADDR_WIDTH  SRAM address.
- ram_wdata  out  DATA_WIDTH  SRAM data.
- ram_wmask  out  STRB_WIDTH  SRAM byte mask.
- busy  out  1  high whenever state is not IDLE or a channel is captured.

Function
REQ-006 SHALL implement FSM states IDLE, WRITE, RESP (one-hot); no outstanding transactions.
REQ-007 SHALL hold internal flags aw_got and w_got; an AW handshake (AWVALID&&AWREADY) captures AWADDR, AWLEN, AWSIZE, AWID and sets aw_got; a W handshake captures WDATA, WSTRB, WLAST, WID and sets w_got.
REQ-008 AWREADY SHALL be combinational: ARESETn && IDLE && !aw_got; WREADY likewise with w_got; AW and W may arrive in either order or the same cycle.
REQ-009 IDLE->WRITE SHALL occur on the edge where both channels become captured; WRITE->RESP always after one cycle; RESP->IDLE on BVALID&&BREADY, clearing aw_got and w_got.
REQ-010 In WRITE, ram_wen SHALL be 1 for exactly one cycle with ram_addr/ram_wdata/ram_wmask driven from captured values; ram_* registered, last values held otherwise.
REQ-011 BVALID SHALL rise on entry to RESP (2 cycles after the completing handshake), hold with stable BID=captured AWID and BRESP until BREADY, then fall next cycle.
REQ-012 AWREADY/WREADY SHALL be 0 throughout WRITE and RESP; earliest next acceptance is the cycle after the B handshake.
REQ-013 AWBURST SHALL be ignored by address logic; only single-beat transfers are supported.

Reset
REQ-014 ARESETn low SHALL asynchronously force IDLE, clear aw_got/w_got, and drive BVALID=0, BRESP=0, BID=0, ram_wen=0, ram_addr=0, ram_wdata=0, ram_wmask=0, busy=0, AWREADY=0, WREADY=0.
REQ-015 Reset asserted mid-transaction SHALL abort it with no ram_wen pulse and no B response afterwards.

Configuration
REQ-016 With macro AXI_SLAVE_PROTOCOL_CHECK_EN defined, BRESP SHALL be SLVERR and ram_wen suppressed when AWLEN!=0, AWSIZE>3'b010, WLAST==0, or WID!=AWID; WRITE/RESP timing unchanged.
REQ-017 Without AXI_SLAVE_PROTOCOL_CHECK_EN, no checks SHALL be made and BRESP SHALL always be 2'b00.

Verification
REQ-018 AW and W same cycle (addr 0x100, data 0xDEADBEEF, strb 4'hF, id 3), BREADY=1 -> ram_wen one pulse at N+1 with those values; BVALID at N+2, BID=3, BRESP=00.
REQ-019 W first at cycle N, AW at N+3 -> WREADY low from N+1; ram_wen at N+4; BVALID at N+5.
REQ-020 BREADY held low 5 cycles -> BVALID, BID, BRESP stable; AWREADY=WREADY=0 until the cycle after BREADY rises.
REQ-021 ARESETn dropped in WRITE -> outputs zero immediately; no BVALID after release; AWREADY=1 the first cycle after release.
REQ-022 With AXI_SLAVE_PROTOCOL_CHECK_EN, AWLEN=1 -> no ram_wen, BRESP=2'b10; without the macro, same stimulus -> ram_wen pulses, BRESP=2'b00.
